regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer.sv | 151 +++++++++++++++
 tb/tb_regfile_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Micro-command sequencer for a register file: decodes WRITE, READ, REPEAT and SWEEP
// commands into registered active-low enables, function codes and read selects.
module regfile_sequencer #(
    parameter logic [2:0] CLR_FUN = 3'b011
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Cmd,
    input  logic        CmdValid,
    output logic        CmdReady,
    output logic [3:0]  RegSel,
    output logic [3:0]  ScrSel,
    output logic [2:0]  FunSel,
    output logic [2:0]  OutASel,
    output logic [2:0]  OutBSel,
    output logic        RdValid,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        REPEAT,
        READ,
        SWEEP
    } state_t;

    state_t      state, state_n;
    logic [2:0]  dst_q, dst_n;
    logic [4:0]  cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  sel_n;
    logic [2:0]  fun_n, outa_n, outb_n;
    logic        rd_n, busy_n, done_n;

    // Indices 0..7 map onto {RegSel, ScrSel} from the MSB down, one bit low.
    function automatic logic [7:0] enable_of(input logic [2:0] i);
        return ~(8'h80 >> i);
    endfunction

    assign CmdReady = (state == IDLE) && Reset;

    // Next-state and next-output values; every output is registered from these.
    always_comb begin
        state_n = state;
        dst_n   = dst_q;
        cnt_n   = cnt;
        idx_n   = idx;
        sel_n   = 8'hFF;
        fun_n   = FunSel;
        outa_n  = OutASel;
        outb_n  = OutBSel;
        rd_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (CmdValid && CmdReady) begin
                    busy_n = 1'b1;
                    dst_n  = Cmd[10:8];
                    unique case (Cmd[15:14])
                        2'b00: begin
                            state_n = WRITE;
                            sel_n   = enable_of(Cmd[10:8]);
                            fun_n   = Cmd[13:11];
                        end
                        2'b01: begin
                            state_n = READ;
                            outa_n  = Cmd[7:5];
                            outb_n  = Cmd[4:2];
                            rd_n    = 1'b1;
                        end
                        2'b10: begin
                            state_n = REPEAT;
                            cnt_n   = Cmd[4:0];
                            sel_n   = enable_of(Cmd[10:8]);
                            fun_n   = Cmd[13:11];
                        end
                        default: begin
                            state_n = SWEEP;
                            idx_n   = 3'd0;
                            sel_n   = enable_of(3'd0);
                            fun_n   = CLR_FUN;
                        end
                    endcase
                end
            end
            WRITE, READ: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            REPEAT: begin
                if (cnt == 5'd0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n  = cnt - 5'd1;
                    sel_n  = enable_of(dst_q);
                    busy_n = 1'b1;
                end
            end
            SWEEP: begin
                if (idx == 3'd7) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    idx_n  = idx + 3'd1;
                    sel_n  = enable_of(idx + 3'd1);
                    fun_n  = CLR_FUN;
                    busy_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state   <= IDLE;
            dst_q   <= 3'd0;
            cnt     <= 5'd0;
            idx     <= 3'd0;
            RegSel  <= 4'hF;
            ScrSel  <= 4'hF;
            FunSel  <= 3'd0;
            OutASel <= 3'd0;
            OutBSel <= 3'd0;
            RdValid <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= state_n;
            dst_q   <= dst_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            RegSel  <= sel_n[7:4];
            ScrSel  <= sel_n[3:0];
            FunSel  <= fun_n;
            OutASel <= outa_n;
            OutBSel <= outb_n;
            RdValid <= rd_n;
            Busy    <= busy_n;
            Done    <= done_n;
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: each driven command pushes its expected
// per-cycle outputs, and every falling edge pops one entry and compares it.
module tb_regfile_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] Cmd;
    logic        CmdValid;
    logic        CmdReady;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  FunSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic        RdValid;
    logic        Busy;
    logic        Done;

    typedef struct packed {
        logic [7:0] sel;
        logic [2:0] fun;
        logic [2:0] outa;
        logic [2:0] outb;
        logic       rd;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         failures = 0;
    int         cycle = 0;
    logic [2:0] funModel = 3'd0;
    logic [2:0] outaModel = 3'd0;
    logic [2:0] outbModel = 3'd0;

    // Expected {RegSel, ScrSel} for index 0..7 (R1..R4, then S1..S4).
    logic [7:0] walk [8] = '{8'b0111_1111, 8'b1011_1111, 8'b1101_1111, 8'b1110_1111,
                             8'b1111_0111, 8'b1111_1011, 8'b1111_1101, 8'b1111_1110};

    regfile_sequencer #(.CLR_FUN(3'b011)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Cmd      (Cmd),
        .CmdValid (CmdValid),
        .CmdReady (CmdReady),
        .RegSel   (RegSel),
        .ScrSel   (ScrSel),
        .FunSel   (FunSel),
        .OutASel  (OutASel),
        .OutBSel  (OutBSel),
        .RdValid  (RdValid),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", tag, cycle, observed, expected);
        end
    endtask

    task automatic pushEntry(input logic [7:0] sel, input logic rd, input logic busy,
                             input logic done, input logic ready);
        exp_t e;
        e.sel   = sel;
        e.fun   = funModel;
        e.outa  = outaModel;
        e.outb  = outbModel;
        e.rd    = rd;
        e.busy  = busy;
        e.done  = done;
        e.ready = ready;
        sb.push_back(e);
    endtask

    task automatic pushIdle(input int n);
        for (int i = 0; i < n; i++) pushEntry(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Reference behaviour of one accepted command, cycle by cycle, ending in its Done cycle.
    task automatic pushCommand(input logic [15:0] c);
        logic [1:0] op;
        logic [2:0] f, d;
        int         n;
        op = c[15:14];
        f  = c[13:11];
        d  = c[10:8];
        n  = int'(c[4:0]);
        case (op)
            2'b00: begin
                funModel = f;
                pushEntry(walk[d], 1'b0, 1'b1, 1'b0, 1'b0);
            end
            2'b01: begin
                outaModel = c[7:5];
                outbModel = c[4:2];
                pushEntry(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
            end
            2'b10: begin
                funModel = f;
                for (int i = 0; i <= n; i++) pushEntry(walk[d], 1'b0, 1'b1, 1'b0, 1'b0);
            end
            default: begin
                funModel = 3'b011;
                for (int i = 0; i < 8; i++) pushEntry(walk[i], 1'b0, 1'b1, 1'b0, 1'b0);
            end
        endcase
        pushEntry(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic stepCheck();
        exp_t e;
        @(negedge Clock);
        cycle++;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        checkOutput("RegSel",   16'(RegSel),   16'(e.sel[7:4]));
        checkOutput("ScrSel",   16'(ScrSel),   16'(e.sel[3:0]));
        checkOutput("FunSel",   16'(FunSel),   16'(e.fun));
        checkOutput("OutASel",  16'(OutASel),  16'(e.outa));
        checkOutput("OutBSel",  16'(OutBSel),  16'(e.outb));
        checkOutput("RdValid",  16'(RdValid),  16'(e.rd));
        checkOutput("Busy",     16'(Busy),     16'(e.busy));
        checkOutput("Done",     16'(Done),     16'(e.done));
        checkOutput("CmdReady", 16'(CmdReady), 16'(e.ready));
    endtask

    task automatic drain();
        while (sb.size() > 0) stepCheck();
    endtask

    // Presents one command for a single edge, then scrambles Cmd to prove it was captured.
    task automatic applyStimulus(input logic [15:0] c);
        Cmd      = c;
        CmdValid = 1'b1;
        pushCommand(c);
        @(posedge Clock);
        #1;
        CmdValid = 1'b0;
        Cmd      = 16'($urandom);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset    = 1'b0;
        CmdValid = 1'b1;
        Cmd      = 16'h1300;
        pushEntry(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        pushEntry(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck();
        stepCheck();
        Reset    = 1'b1;
        CmdValid = 1'b0;
        pushIdle(2);
        drain();

        applyStimulus(16'h1300);
        pushIdle(1);
        drain();

        applyStimulus(16'h40A8);
        pushIdle(2);
        drain();

        applyStimulus(16'h8E04);
        pushIdle(1);
        drain();

        // REPEAT length extremes: Cnt=0 and Cnt=31.
        applyStimulus(16'h9C00);
        pushIdle(1);
        drain();
        applyStimulus(16'hBA1F);
        pushIdle(1);
        drain();

        applyStimulus(16'hC000);
        pushIdle(1);
        drain();

        // Back-to-back WRITEs with CmdValid held high; the next Cmd is offered while busy.
        Cmd      = 16'h2000;
        CmdValid = 1'b1;
        pushCommand(16'h2000);
        pushCommand(16'h2D00);
        pushCommand(16'h3700);
        stepCheck();
        Cmd = 16'h2D00;
        stepCheck();
        stepCheck();
        Cmd = 16'h3700;
        stepCheck();
        stepCheck();
        CmdValid = 1'b0;
        pushIdle(1);
        drain();

        // Reset dropped during the 3rd cycle of a Cnt=9 REPEAT.
        applyStimulus(16'hA909);
        stepCheck();
        stepCheck();
        stepCheck();
        sb.delete();
        Reset     = 1'b0;
        funModel  = 3'd0;
        outaModel = 3'd0;
        outbModel = 3'd0;
        pushEntry(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck();
        Reset = 1'b1;
        pushIdle(4);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
